// File: rtl/dw_mac_engine_if.sv
// -----------------------------------------------------------------------------
// dw_mac_engine_if
// Handshake and data bundle between a job controller / weight buffer /
// activation source / result sink and the depthwise MAC engine.
//
//   master : the environment that starts jobs, feeds weights and
//            activations and consumes results
//   slave  : the engine itself
//
// Signals
//   start, num_win         job request (num_win sampled with start)
//   w_data/w_valid/w_ready weight stream (w_ready pops the weight buffer)
//   a_data/a_valid/a_ready activation stream, taps row-major
//   o_data/o_valid/o_ready saturated per-window result
//   busy, done             job status, done is a one-cycle pulse
// -----------------------------------------------------------------------------
interface dw_mac_engine_if #(
   parameter int DW = 32,
   parameter int NW = 16
);
   logic          start;
   logic [NW-1:0] num_win;
   logic [DW-1:0] w_data;
   logic          w_valid;
   logic          w_ready;
   logic [DW-1:0] a_data;
   logic          a_valid;
   logic          a_ready;
   logic [DW-1:0] o_data;
   logic          o_valid;
   logic          o_ready;
   logic          busy;
   logic          done;

   modport master (
      output start, num_win, w_data, w_valid, a_data, a_valid, o_ready,
      input  w_ready, a_ready, o_data, o_valid, busy, done
   );

   modport slave (
      input  start, num_win, w_data, w_valid, a_data, a_valid, o_ready,
      output w_ready, a_ready, o_data, o_valid, busy, done
   );
endinterface

// File: rtl/dw_mac_engine.sv
// -----------------------------------------------------------------------------
// dw_mac_engine
// Depthwise-convolution multiply-accumulate engine. A job loads KSIZE**2
// weights, then for each of num_win windows accumulates KSIZE**2 signed
// weight*activation products, shifts the sum right by FRAC (floor) and
// emits the result saturated to DW signed bits.
//
// Parameters
//   DW     data width of weights, activations and results (signed)
//   KSIZE  kernel edge, KSIZE**2 taps per window
//   FRAC   fractional bits dropped from the accumulator on output
//   NW     width of the window count
//
// Ports
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   io_mac  dw_mac_engine_if.slave: start/num_win, weight stream,
//           activation stream, result stream, busy, done
//
// Build option
//   DW_MAC_RELU_EN  when defined, negative saturated results are output as 0
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start, outputs quiet
// WLOAD | w_ready high, storing KSIZE**2 weights into w_reg
// ACC   | a_ready high, accumulating one window's taps
// OUT   | o_valid high, holding result until o_ready
// -----------------------------------------------------------------------------
module dw_mac_engine #(
   parameter int DW    = 32,
   parameter int KSIZE = 3,
   parameter int FRAC  = 16,
   parameter int NW    = 16
) (
   input logic            clk,
   input logic            rst_n,
   dw_mac_engine_if.slave io_mac
);

   localparam int NTAP = KSIZE * KSIZE;
   localparam int TW   = (NTAP > 1) ? $clog2(NTAP) : 1;
   localparam int AW   = 2 * DW + $clog2(NTAP);

   localparam logic [TW-1:0]        TAP_LAST = TW'(NTAP - 1);
   localparam logic signed [AW-1:0] SAT_MAX  = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN  = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WLOAD = 2'd1,
      S_ACC   = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t                r_state;
   logic [TW-1:0]         r_tap;
   logic [NW-1:0]         r_num_win;
   logic [NW-1:0]         r_win;
   logic signed [DW-1:0]  r_w [NTAP];
   logic signed [AW-1:0]  r_acc;
   logic [DW-1:0]         r_o_data;
   logic                  r_o_valid;
   logic                  r_w_ready;
   logic                  r_a_ready;
   logic                  r_busy;
   logic                  r_done;

   logic                  w_w_hs;
   logic                  w_a_hs;
   logic                  w_o_hs;
   logic                  w_tap_last;
   logic [NW-1:0]         w_win_next;
   logic signed [2*DW-1:0] w_wx;
   logic signed [2*DW-1:0] w_ax;
   logic signed [2*DW-1:0] w_prod;
   logic signed [AW-1:0]  w_prod_x;
   logic signed [AW-1:0]  w_acc_next;

   // Readies are registered and only ever high in their own state, so the
   // handshakes need no extra state qualification.
   assign w_w_hs     = io_mac.w_valid & r_w_ready;
   assign w_a_hs     = io_mac.a_valid & r_a_ready;
   assign w_o_hs     = io_mac.o_ready & r_o_valid;
   assign w_tap_last = (r_tap == TAP_LAST);
   assign w_win_next = r_win + NW'(1);

   // Operands are sign-extended to the full product width so the multiply
   // is exact regardless of how the tool treats operand signedness.
   assign w_wx       = (2*DW)'(r_w[r_tap]);
   assign w_ax       = (2*DW)'($signed(io_mac.a_data));
   assign w_prod     = w_wx * w_ax;
   assign w_prod_x   = AW'(w_prod);
   assign w_acc_next = r_acc + w_prod_x;

   // Floor shift (arithmetic), then clamp to the signed DW range.
   function automatic logic [DW-1:0] f_sat(input logic signed [AW-1:0] acc);
      logic signed [AW-1:0] sh;
      logic [DW-1:0]        res;
      sh = acc >>> FRAC;
      if (sh > SAT_MAX) begin
         res = SAT_MAX[DW-1:0];
      end else if (sh < SAT_MIN) begin
         res = SAT_MIN[DW-1:0];
      end else begin
         res = sh[DW-1:0];
      end
`ifdef DW_MAC_RELU_EN
      if (res[DW-1]) begin
         res = '0;
      end
`endif
      return res;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_tap     <= '0;
         r_num_win <= '0;
         r_win     <= '0;
         r_acc     <= '0;
         r_o_data  <= '0;
         r_o_valid <= 1'b0;
         r_w_ready <= 1'b0;
         r_a_ready <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         for (int i = 0; i < NTAP; i++) begin
            r_w[i] <= '0;
         end
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (io_mac.start) begin
                  r_num_win <= io_mac.num_win;
                  r_tap     <= '0;
                  r_win     <= '0;
                  r_w_ready <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= S_WLOAD;
               end
            end

            S_WLOAD: begin
               if (w_w_hs) begin
                  r_w[r_tap] <= $signed(io_mac.w_data);
                  if (w_tap_last) begin
                     r_tap     <= '0;
                     r_w_ready <= 1'b0;
                     if (r_num_win == '0) begin
                        // Empty job: weights are still consumed so the
                        // buffer stays aligned with the next job.
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                     end else begin
                        r_acc     <= '0;
                        r_a_ready <= 1'b1;
                        r_state   <= S_ACC;
                     end
                  end else begin
                     r_tap <= r_tap + TW'(1);
                  end
               end
            end

            S_ACC: begin
               if (w_a_hs) begin
                  r_acc <= w_acc_next;
                  if (w_tap_last) begin
                     // Result is formed from the next accumulator value so
                     // o_data is ready together with o_valid.
                     r_tap     <= '0;
                     r_a_ready <= 1'b0;
                     r_o_data  <= f_sat(w_acc_next);
                     r_o_valid <= 1'b1;
                     r_state   <= S_OUT;
                  end else begin
                     r_tap <= r_tap + TW'(1);
                  end
               end
            end

            S_OUT: begin
               if (w_o_hs) begin
                  r_o_valid <= 1'b0;
                  r_win     <= w_win_next;
                  if (w_win_next == r_num_win) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_acc     <= '0;
                     r_a_ready <= 1'b1;
                     r_state   <= S_ACC;
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign io_mac.w_ready = r_w_ready;
   assign io_mac.a_ready = r_a_ready;
   assign io_mac.o_data  = r_o_data;
   assign io_mac.o_valid = r_o_valid;
   assign io_mac.busy    = r_busy;
   assign io_mac.done    = r_done;

endmodule

// File: tb/tb_dw_mac_engine.sv
// -----------------------------------------------------------------------------
// tb_dw_mac_engine
// Two engines (FRAC=16 and FRAC=0) share one stimulus stream. Expected
// window results come from a plain-arithmetic model of the convolution
// (wide signed sum, floor shift, clamp) queued per window; one compare
// process checks every output cycle of both engines against the queues.
// -----------------------------------------------------------------------------
module tb_dw_mac_engine;
   localparam int DW = 32;
   localparam int NW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [NW-1:0] num_win;
   logic [DW-1:0] w_data;
   logic          w_valid;
   logic [DW-1:0] a_data;
   logic          a_valid;
   logic          o_ready;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_q0[$];
   logic        p_stall = 1'b0;
   logic [31:0] p_data  = '0;
   logic [31:0] p_data0 = '0;

   always #5 clk = ~clk;

   dw_mac_engine_if #(.DW(DW), .NW(NW)) mac_if ();
   dw_mac_engine_if #(.DW(DW), .NW(NW)) mac_if0 ();

   assign mac_if.start    = start;
   assign mac_if.num_win  = num_win;
   assign mac_if.w_data   = w_data;
   assign mac_if.w_valid  = w_valid;
   assign mac_if.a_data   = a_data;
   assign mac_if.a_valid  = a_valid;
   assign mac_if.o_ready  = o_ready;
   assign mac_if0.start   = start;
   assign mac_if0.num_win = num_win;
   assign mac_if0.w_data  = w_data;
   assign mac_if0.w_valid = w_valid;
   assign mac_if0.a_data  = a_data;
   assign mac_if0.a_valid = a_valid;
   assign mac_if0.o_ready = o_ready;

   dw_mac_engine #(.DW(DW), .KSIZE(3), .FRAC(16), .NW(NW)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_mac (mac_if)
   );

   dw_mac_engine #(.DW(DW), .KSIZE(3), .FRAC(0), .NW(NW)) u_dut0 (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_mac (mac_if0)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Window result: exact sum, floor shift, clamp, optional ReLU.
   function automatic logic [31:0] model(input int w[9], input int a[9], input int frac);
      logic signed [127:0] s;
      logic signed [127:0] wx;
      logic signed [127:0] ax;
      s = '0;
      for (int i = 0; i < 9; i++) begin
         wx = w[i];
         ax = a[i];
         s  = s + wx * ax;
      end
      s = s >>> frac;
      if (s > 128'sh7FFF_FFFF) s = 128'sh7FFF_FFFF;
      else if (s < -128'sh8000_0000) s = -128'sh8000_0000;
`ifdef DW_MAC_RELU_EN
      if (s < 0) s = '0;
`endif
      return s[31:0];
   endfunction

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("ready_overlap", 32'(mac_if.w_ready & mac_if.a_ready), 32'd0);
         chk("o_valid_pair", 32'(mac_if0.o_valid), 32'(mac_if.o_valid));
         if (mac_if.o_valid === 1'b1) begin
            chk("a_ready_in_out", 32'(mac_if.a_ready), 32'd0);
            if (p_stall) begin
               chk("o_stable", mac_if.o_data, p_data);
               chk("o_stable_f0", mac_if0.o_data, p_data0);
            end
            if (exp_q.size() == 0 || exp_q0.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_out actual=%h expected=none t=%0t", mac_if.o_data, $time);
            end else begin
               chk("o_data", mac_if.o_data, exp_q[0]);
               chk("o_data_f0", mac_if0.o_data, exp_q0[0]);
               if (o_ready) begin
                  void'(exp_q.pop_front());
                  void'(exp_q0.pop_front());
               end
            end
         end
         p_stall = (mac_if.o_valid === 1'b1) && !o_ready;
         p_data  = mac_if.o_data;
         p_data0 = mac_if0.o_data;
         if (mac_if.done === 1'b1) done_cnt++;
      end
   end

   task automatic chk_quiet(input string nm);
      chk({nm, "_o_valid"}, 32'({mac_if0.o_valid, mac_if.o_valid}), 32'd0);
      chk({nm, "_readies"}, 32'({mac_if.w_ready, mac_if.a_ready}), 32'd0);
      chk({nm, "_busy_done"}, 32'({mac_if.busy, mac_if.done, mac_if0.busy}), 32'd0);
      chk({nm, "_o_data"}, mac_if.o_data, 32'd0);
      chk({nm, "_o_data_f0"}, mac_if0.o_data, 32'd0);
   endtask

   // mode: 0 random data, 1 ones ramp, 2 positive saturation, 3 negative saturation
   task automatic run_job(input int nw, input int vp, input int rp, input int mode,
                          input int stall_win, input int abort_tap);
      int ws[9];
      int as[$];
      int wa[9];
      int aa[9];
      int wi, ai, oc, stall, cyc, d0;
      bit fin, lat, dpend, do_abort, aborted;
      for (int i = 0; i < 9; i++) begin
         case (mode)
            1:       ws[i] = 1 << 16;
            2, 3:    ws[i] = 32'h7FFF_FFFF;
            default: ws[i] = ($urandom_range(3) == 0) ? int'($urandom)
                                                      : int'($urandom_range(262144)) - 131072;
         endcase
      end
      for (int k = 0; k < nw * 9; k++) begin
         case (mode)
            1:       as.push_back(((k % 9) + 1) << 16);
            2:       as.push_back(32'h7FFF_FFFF);
            3:       as.push_back(-2147483647);
            default: as.push_back(($urandom_range(5) == 0) ? int'($urandom)
                                                           : int'($urandom_range(2097152)) - 1048576);
         endcase
      end
      for (int wn = 0; wn < nw; wn++) begin
         for (int i = 0; i < 9; i++) begin
            wa[i] = ws[i];
            aa[i] = as[wn * 9 + i];
         end
         exp_q.push_back(model(wa, aa, 16));
         exp_q0.push_back(model(wa, aa, 0));
      end

      @(posedge clk); #1;
      start = 1'b1; num_win = NW'(nw);
      w_valid = 1'b0; a_valid = 1'b0; o_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      wi = 0; ai = 0; oc = 0; stall = 0; cyc = 0; d0 = done_cnt;
      fin = 0; lat = 0; dpend = 0; do_abort = 0; aborted = 0;
      while (!fin && cyc < 4000) begin
         if (do_abort) begin
            rst_n = 1'b0; w_valid = 1'b0; a_valid = 1'b0; o_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk_quiet("abort");
            rst_n = 1'b1;
            exp_q.delete();
            exp_q0.delete();
            aborted = 1;
            fin = 1;
            @(posedge clk); #1;
         end else begin
            w_valid = (wi < 9) && ($urandom_range(99) < vp);
            w_data  = (wi < 9) ? ws[wi] : $urandom;
            a_valid = (ai < nw * 9) && ($urandom_range(99) < vp);
            a_data  = (ai < nw * 9) ? as[ai] : $urandom;
            o_ready = ($urandom_range(99) < rp);
            if (oc == stall_win && mac_if.o_valid === 1'b1 && stall < 5) begin
               o_ready = 1'b0;
               stall++;
            end
            @(negedge clk);
            if (lat) chk("latency_o_valid", 32'(mac_if.o_valid), 32'd1);
            lat = 0;
            if (dpend) begin
               chk("done_pulse", 32'({mac_if.done, mac_if.busy}), 32'd2);
               fin = 1;
            end
            if (w_valid && mac_if.w_ready) begin
               wi++;
               if (wi == 9 && nw == 0) dpend = 1;
            end
            if (a_valid && mac_if.a_ready) begin
               ai++;
               if (ai % 9 == 0) lat = 1;
               if (abort_tap >= 0 && ai == abort_tap) do_abort = 1;
            end
            if (o_valid_hs()) begin
               oc++;
               if (oc == nw) dpend = 1;
            end
            @(posedge clk); #1;
            cyc++;
         end
      end
      w_valid = 1'b0; a_valid = 1'b0; o_ready = 1'b0;
      if (!fin) begin
         checks++;
         failures++;
         $display("FAIL timeout actual=%0d expected=<4000 nw=%0d", cyc, nw);
      end
      if (aborted) begin
         repeat (3) @(negedge clk);
         chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
         chk("abort_idle_busy", 32'(mac_if.busy), 32'd0);
      end else begin
         chk("weights_taken", 32'(wi), 32'd9);
         chk("acts_taken", 32'(ai), 32'(nw * 9));
         chk("outputs_taken", 32'(oc), 32'(nw));
         chk("queue_drained", 32'(exp_q.size()), 32'd0);
         repeat (3) @(negedge clk);
         chk("one_done", 32'(done_cnt - d0), 32'd1);
         chk("idle_busy", 32'(mac_if.busy), 32'd0);
      end
   endtask

   function automatic bit o_valid_hs();
      return (mac_if.o_valid === 1'b1) && o_ready;
   endfunction

   initial begin
      int w1[9];
      int a1[9];
      int wm[9];
      int an[9];
      rst_n = 1'b0; start = 1'b0; num_win = '0;
      w_data = '0; w_valid = 1'b0; a_data = '0; a_valid = 1'b0; o_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_quiet("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         w1[i] = 1 << 16;
         a1[i] = (i + 1) << 16;
         wm[i] = 32'h7FFF_FFFF;
         an[i] = -2147483647;
      end
      chk("pin_ones", model(w1, a1, 16), 32'h002D_0000);
      chk("pin_ones_f0", model(w1, a1, 0), 32'h7FFF_FFFF);
      chk("pin_satpos", model(wm, wm, 0), 32'h7FFF_FFFF);
`ifdef DW_MAC_RELU_EN
      chk("pin_satneg", model(wm, an, 0), 32'h0000_0000);
`else
      chk("pin_satneg", model(wm, an, 0), 32'h8000_0000);
`endif
      for (int i = 0; i < 9; i++) w1[i] = i - 4;
      chk("pin_mixed", model(w1, a1, 16), 32'h0000_003C);
      for (int i = 0; i < 9; i++) begin
         w1[i] = 1;
         a1[i] = 0;
      end
      a1[0] = -1;
`ifdef DW_MAC_RELU_EN
      chk("pin_floor", model(w1, a1, 16), 32'h0000_0000);
`else
      chk("pin_floor", model(w1, a1, 16), 32'hFFFF_FFFF);
`endif

      run_job(1, 100, 100, 1, -1, -1);
      run_job(1, 100, 100, 2, -1, -1);
      run_job(1, 100, 100, 3, -1, -1);
      run_job(3, 100, 100, 0, 1, -1);
      run_job(2, 100, 100, 0, -1, -1);
      for (int j = 0; j < 5; j++) begin
         run_job(int'($urandom_range(4)) + 1, 45, 55, 0, -1, -1);
      end
      run_job(0, 100, 100, 0, -1, -1);
      run_job(0, 50, 100, 0, -1, -1);
      run_job(2, 100, 100, 0, -1, 4);
      run_job(2, 60, 70, 0, -1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
